// File: rtl/traffic_phase_if.sv
// Signal bundle between the intersection phase sequencer and its environment:
// divider tick, enable and sensor inputs; lamp codes, BCD countdowns and phase outputs.
interface traffic_phase_if;
  logic       EN;
  logic       tick;
  logic       sec_req;
  logic [2:0] LAMP_A;
  logic [2:0] LAMP_B;
  logic [3:0] COUNT_A_H;
  logic [3:0] COUNT_A_L;
  logic [3:0] COUNT_B_H;
  logic [3:0] COUNT_B_L;
  logic [1:0] phase;

  modport master (
    output EN, tick, sec_req,
    input  LAMP_A, LAMP_B, COUNT_A_H, COUNT_A_L, COUNT_B_H, COUNT_B_L, phase
  );

  modport slave (
    input  EN, tick, sec_req,
    output LAMP_A, LAMP_B, COUNT_A_H, COUNT_A_L, COUNT_B_H, COUNT_B_L, phase
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer: main/secondary light cycle, lamp codes,
// per-road BCD countdowns, optional sensor-held main green and flashing-yellow mode.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_MG    | main green, secondary red (may hold at 1 awaiting a request)
// S_MY    | main yellow, secondary red
// S_SG    | main red, secondary green
// S_SY    | main red, secondary yellow
// S_FLASH | both lamps blink yellow on tick, counts blank to 00
module traffic_phase_ctrl #(
  parameter int T_MAIN_G = 40,
  parameter int T_SEC_G  = 20,
  parameter int T_Y      = 5,
  parameter int DETECT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  traffic_phase_if.slave  bus
);

  localparam logic [2:0] S_MG    = 3'd0;
  localparam logic [2:0] S_MY    = 3'd1;
  localparam logic [2:0] S_SG    = 3'd2;
  localparam logic [2:0] S_SY    = 3'd3;
  localparam logic [2:0] S_FLASH = 3'd4;

  localparam logic [6:0] CNT_MG = 7'(T_MAIN_G);
  localparam logic [6:0] CNT_SG = 7'(T_SEC_G);
  localparam logic [6:0] CNT_Y  = 7'(T_Y);

  localparam logic [2:0] L_RED  = 3'b100;
  localparam logic [2:0] L_YEL  = 3'b010;
  localparam logic [2:0] L_GRN  = 3'b001;
  localparam logic [2:0] L_DARK = 3'b000;

  logic [2:0] state, state_n;
  logic [6:0] cnt, cnt_n;
  logic       req_pend, req_n;
  logic       flash_on, flash_n;

  logic [2:0] lamp_a_n, lamp_b_n;
  logic [6:0] val_a_n, val_b_n;
  logic [2:0] lamp_a, lamp_b;
  logic [7:0] count_a, count_b;
  logic [1:0] phase_r;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    flash_n = flash_on;
    req_n   = req_pend;

    if (!bus.EN) begin
      state_n = S_FLASH;
      if (state != S_FLASH)
        flash_n = 1'b1;
      else if (bus.tick)
        flash_n = ~flash_on;
    end else if (state == S_FLASH) begin
      state_n = S_MG;
      cnt_n   = CNT_MG;
    end else if (bus.tick) begin
      if (cnt > 7'd1) begin
        cnt_n = cnt - 7'd1;
      end else begin
        case (state)
          S_MG: begin
            // Sensor mode parks main green at 1 until a secondary request is seen.
            if ((DETECT != 0) && !req_pend) begin
              cnt_n = 7'd1;
            end else begin
              state_n = S_MY;
              cnt_n   = CNT_Y;
            end
          end
          S_MY: begin
            state_n = S_SG;
            cnt_n   = CNT_SG;
          end
          S_SG: begin
            state_n = S_SY;
            cnt_n   = CNT_Y;
          end
          S_SY: begin
            state_n = S_MG;
            cnt_n   = CNT_MG;
          end
          default: begin
            state_n = S_MG;
            cnt_n   = CNT_MG;
          end
        endcase
      end
    end

    // Request is consumed when secondary green starts; a new request that cycle survives.
    if ((state == S_MY) && (state_n == S_SG))
      req_n = 1'b0;
    if (bus.sec_req)
      req_n = 1'b1;
  end

  always_comb begin
    lamp_a_n = L_GRN;
    lamp_b_n = L_RED;
    val_a_n  = cnt_n;
    val_b_n  = cnt_n + CNT_Y;
    case (state_n)
      S_MG: begin
        lamp_a_n = L_GRN;
        lamp_b_n = L_RED;
      end
      S_MY: begin
        lamp_a_n = L_YEL;
        lamp_b_n = L_RED;
        val_b_n  = cnt_n;
      end
      S_SG: begin
        lamp_a_n = L_RED;
        lamp_b_n = L_GRN;
        val_a_n  = cnt_n + CNT_Y;
        val_b_n  = cnt_n;
      end
      S_SY: begin
        lamp_a_n = L_RED;
        lamp_b_n = L_YEL;
        val_a_n  = cnt_n;
        val_b_n  = cnt_n;
      end
      S_FLASH: begin
        lamp_a_n = flash_n ? L_YEL : L_DARK;
        lamp_b_n = flash_n ? L_YEL : L_DARK;
        val_a_n  = 7'd0;
        val_b_n  = 7'd0;
      end
      default: begin
        lamp_a_n = L_GRN;
        lamp_b_n = L_RED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_MG;
      cnt      <= CNT_MG;
      req_pend <= 1'b0;
      flash_on <= 1'b0;
      lamp_a   <= L_GRN;
      lamp_b   <= L_RED;
      count_a  <= to_bcd(CNT_MG);
      count_b  <= to_bcd(CNT_MG + CNT_Y);
      phase_r  <= 2'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      req_pend <= req_n;
      flash_on <= flash_n;
      lamp_a   <= lamp_a_n;
      lamp_b   <= lamp_b_n;
      count_a  <= to_bcd(val_a_n);
      count_b  <= to_bcd(val_b_n);
      phase_r  <= (state_n == S_FLASH) ? 2'd3 : state_n[1:0];
    end
  end

  assign bus.LAMP_A    = lamp_a;
  assign bus.LAMP_B    = lamp_b;
  assign bus.COUNT_A_H = count_a[7:4];
  assign bus.COUNT_A_L = count_a[3:0];
  assign bus.COUNT_B_H = count_b[7:4];
  assign bus.COUNT_B_L = count_b[3:0];
  assign bus.phase     = phase_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: three instances (fixed-time, sensor-held,
// and a wide-count variant) stepped one clk at a time against expected snapshots.
module tb_traffic_phase_ctrl;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] DRK = 3'b000;

  typedef struct packed {
    logic [2:0] la;
    logic [2:0] lb;
    logic [7:0] ca;
    logic [7:0] cb;
    logic [1:0] ph;
  } snap_t;

  typedef struct {
    string tag;
    int    k;
    snap_t e;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] en_v   = 3'b111;
  logic [2:0] tick_v = 3'b000;
  logic [2:0] req_v  = 3'b000;

  int n_checks = 0;
  int n_fail   = 0;
  sb_t sb[$];
  snap_t obs [3];

  always #5 clk = ~clk;

  traffic_phase_if i0 ();
  traffic_phase_if i1 ();
  traffic_phase_if i2 ();

  assign i0.EN = en_v[0];  assign i0.tick = tick_v[0];  assign i0.sec_req = req_v[0];
  assign i1.EN = en_v[1];  assign i1.tick = tick_v[1];  assign i1.sec_req = req_v[1];
  assign i2.EN = en_v[2];  assign i2.tick = tick_v[2];  assign i2.sec_req = req_v[2];

  assign obs[0] = {i0.LAMP_A, i0.LAMP_B, i0.COUNT_A_H, i0.COUNT_A_L, i0.COUNT_B_H, i0.COUNT_B_L, i0.phase};
  assign obs[1] = {i1.LAMP_A, i1.LAMP_B, i1.COUNT_A_H, i1.COUNT_A_L, i1.COUNT_B_H, i1.COUNT_B_L, i1.phase};
  assign obs[2] = {i2.LAMP_A, i2.LAMP_B, i2.COUNT_A_H, i2.COUNT_A_L, i2.COUNT_B_H, i2.COUNT_B_L, i2.phase};

  traffic_phase_ctrl #(.T_MAIN_G(3), .T_SEC_G(4), .T_Y(2), .DETECT(0)) u0 (
    .clk(clk), .rst(rst), .bus(i0.slave));
  traffic_phase_ctrl #(.T_MAIN_G(3), .T_SEC_G(4), .T_Y(2), .DETECT(1)) u1 (
    .clk(clk), .rst(rst), .bus(i1.slave));
  traffic_phase_ctrl #(.T_MAIN_G(94), .T_SEC_G(20), .T_Y(5), .DETECT(0)) u2 (
    .clk(clk), .rst(rst), .bus(i2.slave));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic snap_t mk(input logic [2:0] la, input logic [2:0] lb,
                               input int a, input int b, input int ph);
    snap_t s;
    s.la = la;
    s.lb = lb;
    s.ca = {4'(a / 10), 4'(a % 10)};
    s.cb = {4'(b / 10), 4'(b % 10)};
    s.ph = 2'(ph);
    return s;
  endfunction

  function automatic logic [2:0] lamp_a_of(input int ph);
    return (ph == 0) ? GRN : (ph == 1) ? YEL : RED;
  endfunction

  function automatic logic [2:0] lamp_b_of(input int ph);
    return (ph == 2) ? GRN : (ph == 3) ? YEL : RED;
  endfunction

  task automatic expect_snap(input int k, input string tag, input snap_t e);
    sb_t it;
    it.tag = tag;
    it.k   = k;
    it.e   = e;
    sb.push_back(it);
  endtask

  task automatic compare_front();
    sb_t it;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
      return;
    end
    it = sb.pop_front();
    check_val({it.tag, ".lamp_a"},  32'(obs[it.k].la), 32'(it.e.la));
    check_val({it.tag, ".lamp_b"},  32'(obs[it.k].lb), 32'(it.e.lb));
    check_val({it.tag, ".count_a"}, 32'(obs[it.k].ca), 32'(it.e.ca));
    check_val({it.tag, ".count_b"}, 32'(obs[it.k].cb), 32'(it.e.cb));
    check_val({it.tag, ".phase"},   32'(obs[it.k].ph), 32'(it.e.ph));
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, compare at the next negedge.
  task automatic step(input int k, input bit tk, input bit rq, input bit en,
                      input logic [2:0] la, input logic [2:0] lb,
                      input int a, input int b, input int ph, input string tag);
    expect_snap(k, tag, mk(la, lb, a, b, ph));
    tick_v[k] = tk;
    req_v[k]  = rq;
    en_v[k]   = en;
    @(negedge clk);
    tick_v[k] = 1'b0;
    req_v[k]  = 1'b0;
    compare_front();
  endtask

  int cyc_pa [11] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3};
  int cyc_a  [11] = '{3, 2, 1, 2, 1, 6, 5, 4, 3, 2, 1};
  int cyc_b  [11] = '{5, 4, 3, 2, 1, 4, 3, 2, 1, 2, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    expect_snap(0, "reset0", mk(GRN, RED, 3, 5, 0));
    expect_snap(1, "reset1", mk(GRN, RED, 3, 5, 0));
    expect_snap(2, "reset2", mk(GRN, RED, 94, 99, 0));
    repeat (3) compare_front();

    for (int i = 1; i <= 88; i++)
      step(2, 1, 0, 1, GRN, RED, 94 - i, 99 - i, 0, "bcd");

    step(1, 1, 0, 1, GRN, RED, 2, 4, 0, "hold_dec");
    step(1, 1, 0, 1, GRN, RED, 1, 3, 0, "hold_dec");
    for (int i = 0; i < 10; i++)
      step(1, 1, 0, 1, GRN, RED, 1, 3, 0, "hold");
    step(1, 0, 1, 1, GRN, RED, 1, 3, 0, "req_pulse");
    step(1, 1, 0, 1, YEL, RED, 2, 2, 1, "hold_release");
    step(1, 1, 0, 1, YEL, RED, 1, 1, 1, "my");
    step(1, 1, 1, 1, RED, GRN, 6, 4, 2, "my_sg_req");
    step(1, 1, 0, 1, RED, GRN, 5, 3, 2, "sg");
    step(1, 1, 0, 1, RED, GRN, 4, 2, 2, "sg");
    step(1, 1, 0, 1, RED, GRN, 3, 1, 2, "sg");
    step(1, 1, 0, 1, RED, YEL, 2, 2, 3, "sy");
    step(1, 1, 0, 1, RED, YEL, 1, 1, 3, "sy");
    step(1, 1, 0, 1, GRN, RED, 3, 5, 0, "mg");
    step(1, 1, 0, 1, GRN, RED, 2, 4, 0, "mg");
    step(1, 1, 0, 1, GRN, RED, 1, 3, 0, "mg");
    step(1, 1, 0, 1, YEL, RED, 2, 2, 1, "pend_from_my_sg");
    step(1, 1, 0, 1, YEL, RED, 1, 1, 1, "my");
    step(1, 1, 0, 1, RED, GRN, 6, 4, 2, "sg");
    step(1, 1, 0, 1, RED, GRN, 5, 3, 2, "sg");
    step(1, 1, 0, 1, RED, GRN, 4, 2, 2, "sg");
    step(1, 1, 0, 1, RED, GRN, 3, 1, 2, "sg");
    step(1, 1, 0, 1, RED, YEL, 2, 2, 3, "sy");
    step(1, 0, 1, 1, RED, YEL, 2, 2, 3, "sy_req");
    step(1, 1, 0, 1, RED, YEL, 1, 1, 3, "sy");
    step(1, 1, 0, 1, GRN, RED, 3, 5, 0, "mg");
    step(1, 1, 0, 1, GRN, RED, 2, 4, 0, "mg");
    step(1, 1, 0, 1, GRN, RED, 1, 3, 0, "mg");
    step(1, 1, 0, 1, YEL, RED, 2, 2, 1, "pend_from_sy");
    step(1, 1, 0, 1, YEL, RED, 1, 1, 1, "my");
    step(1, 1, 0, 1, RED, GRN, 6, 4, 2, "sg");
    step(1, 1, 0, 1, RED, GRN, 5, 3, 2, "sg");
    step(1, 1, 0, 1, RED, GRN, 4, 2, 2, "sg");
    step(1, 1, 0, 1, RED, GRN, 3, 1, 2, "sg");
    step(1, 1, 0, 1, RED, YEL, 2, 2, 3, "sy");
    step(1, 1, 0, 1, RED, YEL, 1, 1, 3, "sy");
    step(1, 1, 0, 1, GRN, RED, 3, 5, 0, "mg");
    step(1, 1, 0, 1, GRN, RED, 2, 4, 0, "mg");
    step(1, 1, 0, 1, GRN, RED, 1, 3, 0, "mg");
    step(1, 1, 0, 1, GRN, RED, 1, 3, 0, "cleared_hold");

    for (int i = 1; i <= 10; i++)
      step(0, 1, 0, 1, lamp_a_of(cyc_pa[i]), lamp_b_of(cyc_pa[i]),
           cyc_a[i], cyc_b[i], cyc_pa[i], "cycle");
    step(0, 1, 0, 1, GRN, RED, 3, 5, 0, "cycle_wrap");

    step(0, 1, 0, 1, GRN, RED, 2, 4, 0, "to_sg");
    step(0, 1, 0, 1, GRN, RED, 1, 3, 0, "to_sg");
    step(0, 1, 0, 1, YEL, RED, 2, 2, 1, "to_sg");
    step(0, 1, 0, 1, YEL, RED, 1, 1, 1, "to_sg");
    step(0, 1, 0, 1, RED, GRN, 6, 4, 2, "to_sg");
    step(0, 0, 0, 0, YEL, YEL, 0, 0, 3, "flash_entry");
    step(0, 1, 0, 0, DRK, DRK, 0, 0, 3, "flash_t1");
    step(0, 1, 0, 0, YEL, YEL, 0, 0, 3, "flash_t2");
    step(0, 1, 0, 0, DRK, DRK, 0, 0, 3, "flash_t3");
    step(0, 1, 0, 0, YEL, YEL, 0, 0, 3, "flash_t4");
    step(0, 0, 0, 0, YEL, YEL, 0, 0, 3, "flash_idle");
    step(0, 1, 0, 1, GRN, RED, 3, 5, 0, "flash_exit");
    step(0, 1, 0, 1, GRN, RED, 2, 4, 0, "after_flash");

    step(0, 1, 0, 1, GRN, RED, 1, 3, 0, "to_sg2");
    step(0, 1, 0, 1, YEL, RED, 2, 2, 1, "to_sg2");
    step(0, 1, 0, 1, YEL, RED, 1, 1, 1, "to_sg2");
    step(0, 1, 0, 1, RED, GRN, 6, 4, 2, "to_sg2");
    step(0, 1, 0, 1, RED, GRN, 5, 3, 2, "to_sg2");

    #2 rst = 1'b1;
    #1;
    expect_snap(0, "async_rst0", mk(GRN, RED, 3, 5, 0));
    expect_snap(2, "async_rst2", mk(GRN, RED, 94, 99, 0));
    repeat (2) compare_front();
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 1, GRN, RED, 2, 4, 0, "post_rst");

    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Phase sequencer for the two-road intersection: owns the main/secondary light cycle and produces both lamp codes and both two-digit BCD countdowns consumed by the lamp registers and the 7-segment display mux. It advances on a one-cycle `tick` enable from the clock divider, optionally holds main green until the secondary-road sensor requests service, and enters flashing-yellow mode while `EN` is low.

## Interface
Parameters:
- `T_MAIN_G`, 40: main green duration, seconds (1..99)
- `T_SEC_G`, 20: secondary green duration, seconds (1..99)
- `T_Y`, 5: yellow duration, both roads, seconds (1..99)
- `DETECT`, 1: 1 = main green holds at 01 until a secondary request is pending; 0 = fixed-time cycle

Constraints: `T_MAIN_G+T_Y` ≤ 99 and `T_SEC_G+T_Y` ≤ 99.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `EN`  in  1  1 = normal cycle, 0 = flashing-yellow mode; sampled every `clk`
- `tick`  in  1  one-`clk`-wide 1 Hz enable
- `sec_req`  in  1  secondary-road vehicle sensor, level or pulse, synchronous to `clk`
- `LAMP_A`  out  3  main-road lamp {R,Y,G}: 100 red, 010 yellow, 001 green, 000 dark
- `LAMP_B`  out  3  secondary-road lamp, same encoding
- `COUNT_A_H`, `COUNT_A_L`  out  4 each  main-road remaining seconds, BCD tens/ones
- `COUNT_B_H`, `COUNT_B_L`  out  4 each  secondary-road remaining seconds, BCD tens/ones
- `phase`  out  2  current state: 0 MG, 1 MY, 2 SG, 3 SY; FLASH reports 3

## Operation
- States: MG (main green), MY (main yellow), SG (secondary green), SY (secondary yellow), FLASH.
- `cnt` is a 7-bit binary down-counter holding the remaining time of the current phase.
- Lamps:
  - MG: A=001, B=100
  - MY: A=010, B=100
  - SG: A=100, B=001
  - SY: A=100, B=010
- Countdowns, each road shows the remaining time of its own lamp:
  - MG/MY: A=`cnt`; B=`cnt`+T_Y in MG, `cnt` in MY
  - SG/SY: B=`cnt`; A=`cnt`+T_Y in SG, `cnt` in SY
- Binary-to-BCD conversion: values 0..99 only; H = value/10, L = value%10.
- On a `tick` with `cnt`>1: `cnt` decrements by 1.
- On a `tick` with `cnt`==1:
  - MG→MY with `cnt`=T_Y, unless DETECT=1 and `req_pend`=0, in which case MG holds with `cnt`=1.
  - MY→SG with `cnt`=T_SEC_G.
  - SG→SY with `cnt`=T_Y.
  - SY→MG with `cnt`=T_MAIN_G.
- `req_pend`:
  - Set on any `clk` with `sec_req`=1.
  - Cleared on the MY→SG transition.
  - Set wins if both occur in the same cycle.
- FLASH:
  - Entered on any `clk` edge where `EN`=0, from any state; overrides `tick` in the same cycle.
  - Both lamps toggle between 010 and 000 on each `tick`, starting at 010.
  - All counts read 0/0. `req_pend` is held.
- Leaving FLASH: first `clk` edge with `EN`=1 moves to MG with `cnt`=T_MAIN_G, regardless of `tick`.

## Timing
- All outputs are registered. They change only on `clk` edges at which `tick`=1 or `EN` changes state.
- State and counts update on the same edge.
- Reset values: state MG, `cnt`=T_MAIN_G, `req_pend`=0, LAMP_A=001, LAMP_B=100, COUNT_A=T_MAIN_G, COUNT_B=T_MAIN_G+T_Y, phase=0.
- Reset mid-phase returns to the reset state immediately, asynchronously. The first `tick` after release decrements from T_MAIN_G.
- Fixed cycle length with DETECT=0: T_MAIN_G+T_SEC_G+2·T_Y ticks.
- `tick` held high for multiple cycles counts once per cycle. Driving it that way is the divider's responsibility and is not filtered here.

## Test plan
Benches use T_MAIN_G=3, T_SEC_G=4, T_Y=2 unless stated.

- **Reset:** assert `rst` mid-SG → LAMP_A=001, LAMP_B=100, COUNT_A=0/3, COUNT_B=0/5, phase=0 before the next `clk` edge.
- **Full fixed cycle:** DETECT=0, EN=1, 11 ticks →
  - phase sequence 0,0,0,1,1,2,2,2,2,3,3 then 0
  - COUNT_A: 3,2,1,2,1,6,5,4,3,2,1
  - COUNT_B: 5,4,3,2,1,4,3,2,1,2,1
- **Sensor hold:** DETECT=1, no `sec_req` → MG holds with A=0/1, B=0/3 for 10 ticks. Then 1-cycle `sec_req` pulse; next tick → MY, A=B=0/2.
- **Request timing:** `sec_req` pulsed during SY → `req_pend` survives. After the next MG the phase goes MY without holding. A request asserted in the MY→SG cycle remains pending.
- **Flash mode:** `EN`=0 mid-SG, 4 ticks → lamps 010,000,010,000, counts 0/0. `EN`=1 → next `clk` gives MG, COUNT_A=0/3.
- **BCD boundary:** T_MAIN_G=94, T_Y=5 → COUNT_B reset = 9/9. After 4 ticks: COUNT_A=9/0, COUNT_B=9/5. After 84 further ticks (88 total): COUNT_A=0/6, COUNT_B=1/1.
